// File: rtl/flp_burst_decoder_if.sv
// flp_burst_decoder_if: groups the decoder's line input and its decoded outputs.
//   RXp           raw receive pulse line (asynchronous to CLK16)
//   LCW           last valid link code word, bit 0 = first bit on the wire
//   LCW_VALID     one-cycle strobe, new word on LCW
//   NLP_DET       one-cycle strobe, isolated normal link pulse
//   BURST_ERR     one-cycle strobe, malformed burst
//   ABILITY_MATCH level, three consecutive identical valid words
// master: the decoder (consumes RXp, produces the decode results).
// slave : the line side / auto-negotiation arbiter.
interface flp_burst_decoder_if;
  logic        RXp;
  logic [15:0] LCW;
  logic        LCW_VALID;
  logic        NLP_DET;
  logic        BURST_ERR;
  logic        ABILITY_MATCH;

  modport master (input RXp, output LCW, LCW_VALID, NLP_DET, BURST_ERR, ABILITY_MATCH);
  modport slave  (output RXp, input LCW, LCW_VALID, NLP_DET, BURST_ERR, ABILITY_MATCH);
endinterface

// File: rtl/flp_burst_decoder.sv
// flp_burst_decoder: decodes fast-link-pulse bursts on RXp into 16-bit link
// code words, flags isolated normal link pulses, and tracks ability match.
//   CLK16  16 MHz clock
//   RSTn   asynchronous active-low reset, clears everything
//   bus    flp_burst_decoder_if.master (RXp in, LCW/strobes/ABILITY_MATCH out)
// Pulse intervals are measured between synchronised rising edges (PE), so the
// synchroniser latency cancels out of every window test.
module flp_burst_decoder #(
  parameter int D_MIN = 888,
  parameter int D_MAX = 1112,
  parameter int C_MIN = 1776,
  parameter int C_MAX = 2224
) (
  input  logic                CLK16,
  input  logic                RSTn,
  flp_burst_decoder_if.master bus
);
  localparam logic [11:0] DMIN = 12'(D_MIN);
  localparam logic [11:0] DMAX = 12'(D_MAX);
  localparam logic [11:0] CMIN = 12'(C_MIN);
  localparam logic [11:0] CMAX = 12'(C_MAX);
  localparam logic [11:0] DEND = 12'(D_MAX + 1);
  localparam logic [11:0] CEND = 12'(C_MAX + 1);

  typedef enum logic [1:0] {IDLE, EXP_D, EXP_C, ERR} state_e;

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        pe;
  logic [11:0] gap_q, gap_d;
  state_e      state_q, state_d;
  logic [4:0]  bit_idx_q, bit_idx_d, clk_cnt_q, clk_cnt_d;
  logic [15:0] shift_q, shift_d, lcw_q;
  logic        lcw_valid_q, nlp_q, err_q, match_q;
  logic [1:0]  match_cnt_q, match_cnt_d;
  logic        set_valid, set_nlp, set_err, fault;
  logic        win_d, win_c, to_c, to_d;

  assign pe    = rx_sync_q & ~rx_prev_q;
  assign win_d = (gap_q >= DMIN) && (gap_q <= DMAX);
  assign win_c = (gap_q >= CMIN) && (gap_q <= CMAX);
  // A PE landing on the timeout tick wins over the timeout.
  assign to_c  = ~pe && (gap_q == CEND);
  assign to_d  = ~pe && (gap_q == DEND);

  // GAP holds the tick count since the last PE; the PE cycle itself is tick 0,
  // so the register is loaded with 1 and a PE-to-PE interval of N reads as N.
  assign gap_d = pe ? 12'd1 : ((gap_q == 12'hFFF) ? gap_q : gap_q + 12'd1);

  always_ff @(posedge CLK16 or negedge RSTn) begin
    if (!RSTn) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
      rx_prev_q <= 1'b0;
      gap_q     <= '0;
      state_q   <= IDLE;
      bit_idx_q <= '0;
      clk_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= bus.RXp;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      gap_q     <= gap_d;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      clk_cnt_q <= clk_cnt_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    clk_cnt_d = clk_cnt_q;
    shift_d   = shift_q;
    set_valid = 1'b0;
    set_nlp   = 1'b0;
    set_err   = 1'b0;
    fault     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pe) begin
          state_d   = EXP_D;
          clk_cnt_d = 5'd1;
          bit_idx_d = '0;
          shift_d   = '0;
        end
      end
      EXP_D: begin
        if (pe) begin
          if (bit_idx_q == 5'd16) begin
            fault = 1'b1;
          end else if (win_d) begin
            shift_d[bit_idx_q[3:0]] = 1'b1;
            state_d = EXP_C;
          end else if (win_c) begin
            bit_idx_d = bit_idx_q + 5'd1;
            clk_cnt_d = clk_cnt_q + 5'd1;
          end else begin
            fault = 1'b1;
          end
        end else if (to_c) begin
          // End of burst: a full word, a lone pulse, or something malformed.
          state_d = IDLE;
          if (clk_cnt_q == 5'd17 && bit_idx_q == 5'd16) set_valid = 1'b1;
          else if (clk_cnt_q == 5'd1)                   set_nlp   = 1'b1;
          else                                          set_err   = 1'b1;
        end
      end
      EXP_C: begin
        if (pe) begin
          if (win_d) begin
            bit_idx_d = bit_idx_q + 5'd1;
            clk_cnt_d = clk_cnt_q + 5'd1;
            state_d   = EXP_D;
          end else begin
            fault = 1'b1;
          end
        end else if (to_d) begin
          fault = 1'b1;
        end
      end
      default: begin
        // ERR: stay silent until the line has been quiet for a full timeout.
        if (to_c) state_d = IDLE;
      end
    endcase
    if (fault) begin
      set_err = 1'b1;
      state_d = ERR;
    end
  end

  // lcw_q doubles as "previous valid word" for the match comparison.
  always_comb begin
    match_cnt_d = match_cnt_q;
    if (set_valid) begin
      if (shift_q == lcw_q && match_cnt_q != 2'd0)
        match_cnt_d = (match_cnt_q == 2'd3) ? 2'd3 : match_cnt_q + 2'd1;
      else
        match_cnt_d = 2'd1;
    end else if (set_err || set_nlp) begin
      match_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge CLK16 or negedge RSTn) begin
    if (!RSTn) begin
      lcw_q       <= '0;
      lcw_valid_q <= 1'b0;
      nlp_q       <= 1'b0;
      err_q       <= 1'b0;
      match_cnt_q <= '0;
      match_q     <= 1'b0;
    end else begin
      lcw_valid_q <= set_valid;
      nlp_q       <= set_nlp;
      err_q       <= set_err;
      if (set_valid) lcw_q <= shift_q;
      match_cnt_q <= match_cnt_d;
      match_q     <= (match_cnt_d == 2'd3);
    end
  end

  assign bus.LCW           = lcw_q;
  assign bus.LCW_VALID     = lcw_valid_q;
  assign bus.NLP_DET       = nlp_q;
  assign bus.BURST_ERR     = err_q;
  assign bus.ABILITY_MATCH = match_q;
endmodule

// File: tb/tb_flp_burst_decoder.sv
// Bench for flp_burst_decoder with compressed timing windows (same ratios as
// the production values) so that many bursts fit in a short run.
// Stimulus is expressed as RXp rise times; a burst-level model turns each
// burst's pulse list into one expected outcome and the cycle it must appear.
module tb_flp_burst_decoder;
  localparam int DMIN = 24;
  localparam int DMAX = 30;
  localparam int CMIN = 48;
  localparam int CMAX = 60;
  localparam int KV = 0, KN = 1, KE = 2;

  typedef struct {
    int          t;     // cycle on which the strobe is visible
    int          kind;
    logic [15:0] word;
  } ev_t;

  logic CLK16 = 1'b0;
  logic RSTn;
  int   cyc = 0;
  int   npass = 0, nfail = 0;
  int   nvalid = 0, nnlp = 0, nerr = 0;
  int   vcyc = 0, ecyc = 0;
  int   last_rise = 0;
  int   pq[$];
  ev_t  evq[$];
  ev_t  hq[$];
  logic [15:0] exp_lcw = '0;
  logic        exp_match = 1'b0;

  flp_burst_decoder_if bus ();

  flp_burst_decoder #(.D_MIN(DMIN), .D_MAX(DMAX), .C_MIN(CMIN), .C_MAX(CMAX)) dut (
    .CLK16 (CLK16),
    .RSTn  (RSTn),
    .bus   (bus)
  );

  always #5 CLK16 = ~CLK16;
  always @(posedge CLK16) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act === exp) npass++;
    else begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Burst-level model. ts holds absolute RXp rise times of one burst that
  // starts from an idle decoder; the outcome is decided either on a pulse or
  // on a timeout counted from the last pulse, and shows 3 cycles after that.
  function automatic ev_t model(input int ts[$]);
    ev_t         e;
    int          bits, nclk, g, last;
    bit          after_data;
    logic [15:0] w;
    bits = 0; nclk = 1; after_data = 1'b0; w = '0;
    e.word = '0;
    for (int i = 1; i < ts.size(); i++) begin
      g = ts[i] - ts[i-1];
      if (after_data) begin
        if (g > DMAX + 1) begin
          e.kind = KE; e.t = ts[i-1] + DMAX + 1 + 3; return e;
        end
        if (g >= DMIN && g <= DMAX) begin
          bits++; nclk++; after_data = 1'b0;
        end else begin
          e.kind = KE; e.t = ts[i] + 3; return e;
        end
      end else begin
        if (bits == 16) begin
          e.kind = KE; e.t = ts[i] + 3; return e;
        end else if (g >= DMIN && g <= DMAX) begin
          w[bits] = 1'b1; after_data = 1'b1;
        end else if (g >= CMIN && g <= CMAX) begin
          bits++; nclk++;
        end else begin
          e.kind = KE; e.t = ts[i] + 3; return e;
        end
      end
    end
    last = ts[ts.size()-1];
    if (after_data) begin
      e.kind = KE; e.t = last + DMAX + 1 + 3;
    end else begin
      e.t = last + CMAX + 1 + 3;
      if (nclk == 17 && bits == 16) begin e.kind = KV; e.word = w; end
      else if (nclk == 1)             e.kind = KN;
      else                            e.kind = KE;
    end
    return e;
  endfunction

  // Pulse offsets: clock k at k*cs, data for bit k at k*cs+dofs when set.
  task automatic gen(input logic [15:0] w, input int cs, input int dofs, input int nclk);
    pq.delete();
    for (int k = 0; k < nclk; k++) begin
      pq.push_back(k * cs);
      if (k < nclk - 1 && k < 16 && w[k]) pq.push_back(k * cs + dofs);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin @(posedge CLK16); #1; end
  endtask

  task automatic drive_list(input int a[$]);
    foreach (a[i]) begin
      wait_until(a[i]);
      bus.RXp = 1'b1;
      @(posedge CLK16); #1;
      bus.RXp = 1'b0;
    end
  endtask

  task automatic run_abs(input int a[$]);
    evq.push_back(model(a));
    last_rise = a[a.size()-1];
    drive_list(a);
    wait_until(last_rise + CMAX + 20);
  endtask

  task automatic run_burst();
    int a[$];
    int base;
    base = cyc + 10;
    foreach (pq[i]) a.push_back(base + pq[i]);
    run_abs(a);
  endtask

  // Per-cycle compare of every output against the model.
  always @(negedge CLK16) begin
    ev_t  e;
    logic ev_v, ev_n, ev_e;
    ev_v = 1'b0; ev_n = 1'b0; ev_e = 1'b0;
    if (!RSTn) begin
      exp_lcw = '0; exp_match = 1'b0; hq.delete();
    end else if (evq.size() > 0 && evq[0].t == cyc) begin
      e = evq.pop_front();
      ev_v = (e.kind == KV); ev_n = (e.kind == KN); ev_e = (e.kind == KE);
      if (ev_v) exp_lcw = e.word;
      hq.push_back(e);
      if (hq.size() > 3) void'(hq.pop_front());
      exp_match = (hq.size() == 3) && hq[0].kind == KV && hq[1].kind == KV &&
                  hq[2].kind == KV && hq[0].word == hq[1].word && hq[1].word == hq[2].word;
    end
    chk("cycle", {12'd0, bus.LCW_VALID, bus.NLP_DET, bus.BURST_ERR, bus.ABILITY_MATCH, bus.LCW},
                 {12'd0, ev_v, ev_n, ev_e, exp_match, exp_lcw});
    if (bus.LCW_VALID) begin nvalid++; vcyc = cyc; end
    if (bus.NLP_DET)   nnlp++;
    if (bus.BURST_ERR) begin nerr++; ecyc = cyc; end
  end

  logic [15:0] acc_w [4] = '{16'h5555, 16'h5555, 16'h00FF, 16'h00F0};
  int          acc_cs[4] = '{54, 54, 48, 60};
  int          acc_do[4] = '{24, 30, 24, 30};
  logic [15:0] rej_w [4] = '{16'h5555, 16'h0001, 16'h0000, 16'h0000};
  int          rej_cs[4] = '{54, 55, 47, 61};
  int          rej_do[4] = '{23, 24, 24, 30};

  initial begin
    ev_t mk;
    int  n0, a[$], b[$], base, cut;
    RSTn = 1'b0;
    bus.RXp = 1'b0;
    repeat (5) begin @(posedge CLK16); #1; end
    chk("rst_lcw", 32'(bus.LCW), 32'h0);
    chk("rst_strobes", {28'd0, bus.LCW_VALID, bus.NLP_DET, bus.BURST_ERR, bus.ABILITY_MATCH}, 32'h0);
    RSTn = 1'b1;
    repeat (5) begin @(posedge CLK16); #1; end

    // Nominal 0x8100 burst, model pinned by hand first.
    gen(16'h8100, 54, 27, 17);
    mk = model(pq);
    chk("model_kind", 32'(mk.kind), 32'(KV));
    chk("model_word", 32'(mk.word), 32'h8100);
    chk("model_time", 32'(mk.t), 32'(16 * 54 + CMAX + 4));
    run_burst();
    chk("nom_lcw", 32'(bus.LCW), 32'h8100);
    chk("nom_nvalid", 32'(nvalid), 32'd1);
    chk("nom_nerr_nlp", 32'(nerr + nnlp), 32'd0);
    chk("nom_latency", 32'(vcyc - (last_rise + 2)), 32'(CMAX + 2));
    chk("nom_match", 32'(bus.ABILITY_MATCH), 32'd0);

    // Ability match: three identical words then a different one.
    gen(16'h41E1, 54, 27, 17);
    run_burst(); run_burst();
    chk("am_two", 32'(bus.ABILITY_MATCH), 32'd0);
    run_burst();
    chk("am_three", 32'(bus.ABILITY_MATCH), 32'd1);
    gen(16'h4001, 54, 27, 17);
    run_burst();
    chk("am_four", 32'(bus.ABILITY_MATCH), 32'd0);
    chk("am_lcw", 32'(bus.LCW), 32'h4001);

    // Lone pulse -> NLP.
    pq.delete(); pq.push_back(0);
    mk = model(pq);
    chk("model_nlp", 32'(mk.kind), 32'(KN));
    n0 = nnlp;
    run_burst();
    chk("nlp_count", 32'(nnlp - n0), 32'd1);
    chk("nlp_lcw", 32'(bus.LCW), 32'h4001);

    // Window edges: accepted.
    for (int i = 0; i < 4; i++) begin
      n0 = nvalid;
      gen(acc_w[i], acc_cs[i], acc_do[i], 17);
      run_burst();
      chk("edge_acc_cnt", 32'(nvalid - n0), 32'd1);
      chk("edge_acc_lcw", 32'(bus.LCW), 32'(acc_w[i]));
    end
    // Window edges: rejected, each followed by a clean burst.
    for (int i = 0; i < 4; i++) begin
      n0 = nerr;
      gen(rej_w[i], rej_cs[i], rej_do[i], 17);
      run_burst();
      chk("edge_rej_cnt", 32'(nerr - n0), 32'd1);
      gen(16'h1234, 54, 27, 17);
      run_burst();
      chk("edge_rej_after", 32'(bus.LCW), 32'h1234);
    end

    // Truncated burst after a matching run.
    gen(16'h41E1, 54, 27, 17);
    run_burst(); run_burst(); run_burst();
    chk("trunc_pre_match", 32'(bus.ABILITY_MATCH), 32'd1);
    n0 = nerr;
    gen(16'h41E1, 54, 27, 10);
    run_burst();
    chk("trunc_err", 32'(nerr - n0), 32'd1);
    chk("trunc_time", 32'(ecyc - last_rise), 32'(CMAX + 4));
    chk("trunc_lcw", 32'(bus.LCW), 32'h41E1);
    chk("trunc_match", 32'(bus.ABILITY_MATCH), 32'd0);

    // Reset after bit 7 of a 0xA5A5 burst.
    gen(16'hA5A5, 54, 27, 17);
    base = cyc + 10;
    cut  = base + 7 * 54 + 27;
    foreach (pq[i]) begin
      if (base + pq[i] <= cut) a.push_back(base + pq[i]);
      else                     b.push_back(base + pq[i]);
    end
    drive_list(a);
    repeat (5) begin @(posedge CLK16); #1; end
    RSTn = 1'b0;
    repeat (4) begin @(posedge CLK16); #1; end
    chk("midrst_out", {11'd0, bus.LCW_VALID, bus.NLP_DET, bus.BURST_ERR, bus.ABILITY_MATCH, bus.LCW}, 32'h0);
    RSTn = 1'b1;
    n0 = nerr;
    run_abs(b);
    chk("midrst_err", 32'(nerr - n0), 32'd1);
    n0 = nvalid;
    run_burst();
    chk("midrst_valid", 32'(nvalid - n0), 32'd1);
    chk("midrst_lcw", 32'(bus.LCW), 32'hA5A5);

    chk("evq_drained", 32'(evq.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, npass + nfail);
    $finish;
  end
endmodule
